// File: rtl/fp_cmp_resolve128.sv
// rtl/fp_cmp_resolve128.sv - FP compare predicate resolver with 2-entry result FIFO and NV status
//
// Resolves the selected compare predicate to a taken bit, derives the IEEE
// invalid (NV) flag for signaling predicates, and buffers {taken, nv, tag}
// in a 2-entry FIFO toward the branch/set-flag stage. Keeps a sticky NV bit
// and a saturating NV event counter, both updated at push time.
//
// Optional feature macro: FP_CMP_TRAP_EN (adds nv_trap_en_i / trap_o).
//
// Ports:
//   clk_i, rst_ni           clock, synchronous active-low reset
//   cmp_valid_i/cmp_ready_o upstream handshake (ready = FIFO not full)
//   cmp_i, nan_i, snan_i    condition vector and NaN flags from compare unit
//   cond_i, tag_i           predicate selector and issue tag
//   res_valid_o/res_ready_i downstream handshake
//   res_taken_o, res_nv_o,  head entry contents (zero while empty)
//   res_tag_o
//   nv_sticky_o, nv_cnt_o   sticky invalid flag, saturating invalid count
//   nv_clr_i                clears sticky flag and counter
//   nv_trap_en_i, trap_o    (FP_CMP_TRAP_EN only) trap enable, one-cycle trap pulse

module fp_cmp_resolve128 #(
  parameter int TAGW = 6,
  parameter int CNTW = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cmp_valid_i,
  output logic            cmp_ready_o,
  input  logic [15:0]     cmp_i,
  input  logic            nan_i,
  input  logic            snan_i,
  input  logic [3:0]      cond_i,
  input  logic [TAGW-1:0] tag_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic            res_taken_o,
  output logic            res_nv_o,
  output logic [TAGW-1:0] res_tag_o,
  output logic            nv_sticky_o,
  input  logic            nv_clr_i,
`ifdef FP_CMP_TRAP_EN
  input  logic            nv_trap_en_i,
  output logic            trap_o,
`endif
  output logic [CNTW-1:0] nv_cnt_o
);

  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  logic [1:0]      count_q, count_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      taken_q;
  logic [1:0]      nv_q;
  logic [TAGW-1:0] tag_q [2];
  logic            sticky_q, sticky_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic push, pop;
  logic signaling, nv_new, taken_new;

  assign cmp_ready_o = (count_q != 2'd2);
  assign res_valid_o = (count_q != 2'd0);
  assign push        = cmp_valid_i & cmp_ready_o;
  assign pop         = res_valid_o & res_ready_i;

  // lt, le and their negations signal on NaN; eq/ne/unordered/ordered/magnitude are quiet
  assign signaling = (cond_i == 4'd1) | (cond_i == 4'd2) | (cond_i == 4'd9) | (cond_i == 4'd10);
  assign nv_new    = snan_i | (nan_i & signaling);

`ifdef FP_CMP_TRAP_EN
  logic trap_q;
  // a trapping compare must not be seen as taken downstream
  assign taken_new = cmp_i[cond_i] & ~(nv_new & nv_trap_en_i);
  assign trap_o    = trap_q;
`else
  assign taken_new = cmp_i[cond_i];
`endif

  // head entry is masked while empty so stale storage never leaks out
  assign res_taken_o = res_valid_o & taken_q[rd_ptr_q];
  assign res_nv_o    = res_valid_o & nv_q[rd_ptr_q];
  assign res_tag_o   = res_valid_o ? tag_q[rd_ptr_q] : '0;
  assign nv_sticky_o = sticky_q;
  assign nv_cnt_o    = cnt_q;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // a new invalid event takes priority over a same-cycle clear
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (push && nv_new) begin
      sticky_d = 1'b1;
      if (nv_clr_i)            cnt_d = CNT_ONE;
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
    end else if (nv_clr_i) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      taken_q  <= 2'b00;
      nv_q     <= 2'b00;
      tag_q[0] <= '0;
      tag_q[1] <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      if (push) begin
        taken_q[wr_ptr_q] <= taken_new;
        nv_q[wr_ptr_q]    <= nv_new;
        tag_q[wr_ptr_q]   <= tag_i;
      end
    end
  end

`ifdef FP_CMP_TRAP_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) trap_q <= 1'b0;
    else         trap_q <= push & nv_new & nv_trap_en_i;
  end
`endif

endmodule

// File: doc/fp_cmp_resolve128.md
Name: fp_cmp_resolve128

Overview:
- Consumer end of the 128-bit FP compare interface.
- Accepts the 16-bit condition vector plus nan/snan produced by the compare unit, together with a 4-bit condition selector and an issue tag.
- Resolves the selected predicate to a single taken bit and raises IEEE invalid (NV) for signaling predicates.
- Buffers results in a 2-entry FIFO under valid/ready handshake toward the branch/set-flag stage, and maintains a sticky NV status bit and a saturating exception counter.

Parameters:
- TAGW, 6, width of the issue tag carried with each compare.
- CNTW, 8, width of the saturating invalid-event counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  synchronous active-low reset.
- cmp_valid_i  in  1  upstream compare result valid.
- cmp_ready_o  out  1  block can accept; equals !full.
- cmp_i  in  16  condition vector: bit0 eq, 1 lt, 2 le, 3 magnitude-lt, 4 unordered, 8 ne, 9 !lt, 10 !le, 11 !magnitude-lt, 12 ordered; bits 5-7 and 13-15 are zero.
- nan_i  in  1  either operand NaN.
- snan_i  in  1  either operand signaling NaN.
- cond_i  in  4  predicate select, an index into cmp_i.
- tag_i  in  TAGW  issue tag.
- res_valid_o  out  1  result available.
- res_ready_i  in  1  downstream accepts result.
- res_taken_o  out  1  resolved predicate.
- res_nv_o  out  1  this compare raised invalid.
- res_tag_o  out  TAGW  tag of the head entry.
- nv_sticky_o  out  1  sticky invalid status.
- nv_clr_i  in  1  clears nv_sticky_o and the counter.
- nv_cnt_o  out  CNTW  saturating count of invalid events.

Behaviour:
- Reset (rst_ni=0 at clock edge) values:
  - FIFO emptied; res_valid_o=0; res_taken_o=0; res_nv_o=0; res_tag_o=0.
  - nv_sticky_o=0; nv_cnt_o=0.
  - cmp_ready_o=1 from the first cycle after reset.
  - Reset mid-operation discards all buffered entries.
- Push occurs when cmp_valid_i & cmp_ready_o. Pop occurs when res_valid_o & res_ready_i.
- Resolution, computed combinationally at push and stored in the entry:
  - taken = cmp_i[cond_i]. Selectors 5-7 and 13-15 therefore give taken=0.
  - Signaling predicates are cond_i ∈ {1,2,9,10}. All other selectors are quiet.
  - nv = snan_i | (nan_i & signaling).
  - When nan_i=1, taken is still cmp_i[cond_i], unmodified.
- FIFO:
  - 2 entries; 2-bit occupancy count 0..2; 1-bit read and write pointers that wrap 1→0.
  - cmp_ready_o = (count != 2), registered-state based. It does not look ahead at a same-cycle pop.
  - Latency: an entry pushed at edge N is visible on res_* after edge N (1 cycle). There is no bypass.
  - res_valid_o = (count != 0). res_* present the head entry and hold stable while res_valid_o=1 and res_ready_i=0.
  - Simultaneous push and pop at count 1: count stays 1, both pointers advance.
  - Pop at count 0 and push at count 2 cannot occur by construction.
- Status:
  - On push with nv=1: nv_sticky_o←1 and nv_cnt_o←nv_cnt_o+1, saturating at 2^CNTW-1.
  - nv_clr_i with no nv push: sticky←0, cnt←0.
  - nv_clr_i in the same cycle as an nv push: sticky=1, cnt=1 (set wins over clear).
  - Status updates at push time, independent of when the entry is popped.

Optional Feature:
- FP_CMP_TRAP_EN: adds input nv_trap_en_i (1) and output trap_o (1).
- With the macro defined:
  - trap_o pulses high for exactly one cycle, on the cycle after the push edge, when a pushed entry has nv=1 and nv_trap_en_i=1.
  - When trap_o pulses, that entry's res_taken_o is forced to 0.
  - trap_o resets to 0.
- Without the macro: neither port exists and the entry's taken is never forced.

Test Plan:
- Reset with rst_ni=0 for 2 cycles -> all outputs 0 except cmp_ready_o=1; nv_cnt_o=0.
- Push cmp_i=16'h1E00 (bits 9-12 set), cond_i=9, tag_i=5, nan_i=0, res_ready_i=1 -> next cycle res_valid_o=1, res_taken_o=1, res_nv_o=0, res_tag_o=5; the FIFO is empty the following cycle.
- Push cmp_i=16'h1710 (bits 4, 8, 9, 10, 12 set), nan_i=1, snan_i=0, cond_i=1 -> res_taken_o=0, res_nv_o=1, nv_sticky_o=1, nv_cnt_o=1. Then push with cond_i=4 -> res_taken_o=1, res_nv_o=0, nv_cnt_o stays 1.
- Hold res_ready_i=0 and push tags 1, 2 -> cmp_ready_o=0 after the second push and a third push is refused. res_tag_o stays 1 while held. Then res_ready_i=1 with a simultaneous push of tag 3 -> outputs in order 1, 2, 3.
- snan_i=1 on 260 consecutive pushes -> nv_cnt_o saturates at 255. nv_clr_i together with an nv push -> nv_sticky_o=1, nv_cnt_o=1. nv_clr_i alone -> both 0.
- With FP_CMP_TRAP_EN, nv_trap_en_i=1, snan_i=1, cmp_i[0]=1, cond_i=0 -> trap_o high for one cycle, res_taken_o=0, res_nv_o=1.
